// File: rtl/layermixer.sv
// rtl/layermixer.sv - N-layer RGB compositor with frame-committed per-layer modes and display blanking
module layermixer #(
    parameter int NUM_LAYERS   = 2,
    parameter int COLOUR_BITS  = 6,
    parameter int SAMPLE_PHASE = 0,
    parameter int PHASES       = 6,
    localparam int PIX_W       = 3 * COLOUR_BITS
) (
    input  logic                      sysClk,
    input  logic                      nReset,
    input  logic [2:0]                sysClkPhase,
    input  logic                      frameStart,
    input  logic                      displayEnable,
    input  logic [NUM_LAYERS*PIX_W-1:0] layerRgb,
    input  logic [NUM_LAYERS*2-1:0]   layerMode,
    input  logic [PIX_W-1:0]          keyColour,
    output logic [PIX_W-1:0]          rgbOut,
    output logic                      rgbValid,
    output logic [NUM_LAYERS*2-1:0]   modeActive
);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_OPAQUE = 2'b01;
    localparam logic [1:0] MODE_KEY    = 2'b10;
    localparam logic [1:0] MODE_BLEND  = 2'b11;
    localparam logic [NUM_LAYERS*2-1:0] MODE_RST = {{(NUM_LAYERS*2-2){1'b0}}, MODE_OPAQUE};

    logic                        tick;
    logic                        s1_valid;
    logic                        s1_de;
    logic [NUM_LAYERS*PIX_W-1:0] s1_rgb;
    logic [PIX_W-1:0]            s1_key;
    logic [NUM_LAYERS*2-1:0]     s1_mode;
    logic [PIX_W-1:0]            acc;

    assign tick = (int'(sysClkPhase) == SAMPLE_PHASE) && (int'(sysClkPhase) < PHASES);

    function automatic logic [PIX_W-1:0] blend(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic [PIX_W-1:0]       r;
        logic [COLOUR_BITS:0]   s;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            s = {1'b0, a[c*COLOUR_BITS +: COLOUR_BITS]} + {1'b0, b[c*COLOUR_BITS +: COLOUR_BITS]};
            r[c*COLOUR_BITS +: COLOUR_BITS] = s[COLOUR_BITS:1];
        end
        return r;
    endfunction

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            modeActive <= MODE_RST;
        end else if (frameStart) begin
            modeActive <= layerMode;
        end
    end

    // The committed mode is snapshotted alongside the pixel so a commit on the
    // tick edge or the compose edge never affects the pixel already in flight.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            s1_valid <= 1'b0;
            s1_de    <= 1'b0;
            s1_rgb   <= '0;
            s1_key   <= '0;
            s1_mode  <= MODE_RST;
        end else begin
            s1_valid <= tick;
            if (tick) begin
                s1_de   <= displayEnable;
                s1_rgb  <= layerRgb;
                s1_key  <= keyColour;
                s1_mode <= modeActive;
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            case (s1_mode[2*i +: 2])
                MODE_OPAQUE: acc = s1_rgb[i*PIX_W +: PIX_W];
                MODE_KEY: begin
                    if (i == 0 || s1_rgb[i*PIX_W +: PIX_W] != s1_key) begin
                        acc = s1_rgb[i*PIX_W +: PIX_W];
                    end
                end
                MODE_BLEND: begin
                    // Bottom layer has nothing beneath it to blend with.
                    if (i == 0) begin
                        acc = s1_rgb[i*PIX_W +: PIX_W];
                    end else begin
                        acc = blend(acc, s1_rgb[i*PIX_W +: PIX_W]);
                    end
                end
                MODE_OFF: acc = acc;
                default:  acc = acc;
            endcase
        end
    end

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            rgbOut   <= '0;
            rgbValid <= 1'b0;
        end else begin
            rgbValid <= s1_valid;
            if (s1_valid) begin
                rgbOut <= s1_de ? acc : '0;
            end
        end
    end

endmodule

// File: tb/tb_layermixer.sv
// tb/tb_layermixer.sv - directed self-checking bench for layermixer (2-layer and 4-layer instances)
module tb_layermixer;

    localparam int PW = 18;

    logic            sysClk = 1'b0;
    logic            nReset;
    logic [2:0]      sysClkPhase;
    logic            frameStart;
    logic            displayEnable;
    logic [2*PW-1:0] layerRgb;
    logic [3:0]      layerMode;
    logic [PW-1:0]   keyColour;
    logic [PW-1:0]   rgbOut;
    logic            rgbValid;
    logic [3:0]      modeActive;
    logic [4*PW-1:0] layerRgb4;
    logic [7:0]      layerMode4;
    logic [PW-1:0]   rgbOut4;
    logic            rgbValid4;
    logic [7:0]      modeActive4;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] px_out, px_out4;
    logic [5:0]    px_valid, px_valid4;
    int            vcount;

    always #5 sysClk = ~sysClk;

    layermixer #(.NUM_LAYERS(2)) dut (
        .sysClk(sysClk), .nReset(nReset), .sysClkPhase(sysClkPhase), .frameStart(frameStart),
        .displayEnable(displayEnable), .layerRgb(layerRgb), .layerMode(layerMode), .keyColour(keyColour),
        .rgbOut(rgbOut), .rgbValid(rgbValid), .modeActive(modeActive)
    );

    layermixer #(.NUM_LAYERS(4)) dut4 (
        .sysClk(sysClk), .nReset(nReset), .sysClkPhase(sysClkPhase), .frameStart(frameStart),
        .displayEnable(displayEnable), .layerRgb(layerRgb4), .layerMode(layerMode4), .keyColour(keyColour),
        .rgbOut(rgbOut4), .rgbValid(rgbValid4), .modeActive(modeActive4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rgb(input int r, input int g, input int b);
        return {r[5:0], g[5:0], b[5:0]};
    endfunction

    // One full pixel period; frameStart is driven on phase fs_p (-1 = never).
    task automatic pixel(input int fs_p);
        px_valid  = '0;
        px_valid4 = '0;
        for (int p = 0; p < 6; p++) begin
            sysClkPhase = 3'(p);
            frameStart  = (p == fs_p);
            @(posedge sysClk);
            #1;
            px_valid[p]  = rgbValid;
            px_valid4[p] = rgbValid4;
            if (p == 1) begin
                px_out  = rgbOut;
                px_out4 = rgbOut4;
            end
        end
        frameStart = 1'b0;
    endtask

    task automatic expect_pixel(input string tag, input logic [PW-1:0] exp, input int fs_p);
        pixel(fs_p);
        check({tag, "_out"}, 32'(px_out), 32'(exp));
        check({tag, "_hold"}, 32'(rgbOut), 32'(exp));
        check({tag, "_valid"}, 32'(px_valid), 32'b000010);
    endtask

    initial begin
        nReset        = 1'b0;
        sysClkPhase   = 3'd0;
        frameStart    = 1'b0;
        displayEnable = 1'b1;
        layerRgb      = '0;
        layerMode     = '0;
        keyColour     = '0;
        layerRgb4     = '0;
        layerMode4    = '0;
        #12;
        check("rst_out", 32'(rgbOut), 32'h0);
        check("rst_valid", 32'(rgbValid), 32'h0);
        check("rst_mode", 32'(modeActive), 32'b0001);
        check("rst_mode4", 32'(modeActive4), 32'b00000001);
        @(negedge sysClk);
        nReset = 1'b1;

        // Commit L0 opaque / L1 key; 4-layer {01,10,11,00}
        layerRgb   = {18'h0, 18'h3FFFF};
        layerMode  = 4'b10_01;
        layerMode4 = 8'b00_11_10_01;
        pixel(3);
        check("commit_mode", 32'(modeActive), 32'b1001);
        check("commit_mode4", 32'(modeActive4), 32'b00111001);

        // T1 colour key
        expect_pixel("t1_keyed", 18'h3FFFF, -1);
        layerRgb = {18'h00FC0, 18'h3FFFF};
        expect_pixel("t1_shown", 18'h00FC0, -1);

        // T2 blend plus 4-layer composition (L1 keyed out, L2 blends onto L0, L3 off)
        layerRgb  = {rgb(0, 63, 11), rgb(63, 0, 10)};
        layerRgb4 = {18'h3FFFF, rgb(0, 63, 11), 18'h0, rgb(63, 0, 10)};
        layerMode = 4'b11_01;
        pixel(3);
        expect_pixel("t2_blend", rgb(31, 31, 10), -1);
        check("t6_four_layer", 32'(px_out4), 32'(rgb(31, 31, 10)));
        check("t6_four_valid", 32'(px_valid4), 32'b000010);
        layerRgb = {18'h3FFFF, 18'h3FFFF};
        expect_pixel("blend_max", 18'h3FFFF, -1);
        layerRgb = {18'h0, rgb(1, 1, 1)};
        expect_pixel("blend_floor", 18'h0, -1);
        layerRgb = {rgb(3, 6, 63), rgb(2, 5, 62)};
        expect_pixel("blend_mixed", rgb(2, 5, 62), -1);

        // T3 mode tearing
        layerRgb  = {18'h00FC0, 18'h3FFFF};
        layerMode = 4'b10_01;
        pixel(3);
        expect_pixel("t3_base", 18'h00FC0, -1);
        layerMode = 4'b00_01;
        expect_pixel("t3_nocommit", 18'h00FC0, -1);
        check("t3_mode_held", 32'(modeActive), 32'b1001);
        expect_pixel("t3_fs_on_tick", 18'h00FC0, 0);
        check("t3_mode_new", 32'(modeActive), 32'b0001);
        expect_pixel("t3_after", 18'h3FFFF, -1);
        layerMode = 4'b10_01;
        expect_pixel("t3_fs_on_s2", 18'h3FFFF, 1);
        expect_pixel("t3_after_s2", 18'h00FC0, -1);

        // T4 blanking
        displayEnable = 1'b0;
        layerRgb      = {18'h3FFFF, 18'h3FFFF};
        expect_pixel("t4_blank_a", 18'h0, -1);
        expect_pixel("t4_blank_b", 18'h0, -1);
        displayEnable = 1'b1;
        expect_pixel("t4_unblank", 18'h3FFFF, -1);

        // T5 async reset during stage 2
        sysClkPhase = 3'd0;
        @(posedge sysClk);
        #1;
        sysClkPhase = 3'd1;
        @(posedge sysClk);
        #1;
        check("t5_pre_valid", 32'(rgbValid), 32'h1);
        nReset = 1'b0;
        #1;
        check("t5_async_out", 32'(rgbOut), 32'h0);
        check("t5_async_valid", 32'(rgbValid), 32'h0);
        check("t5_async_mode", 32'(modeActive), 32'b0001);
        check("t5_async_mode4", 32'(modeActive4), 32'b00000001);
        @(negedge sysClk);
        nReset = 1'b1;

        vcount = 0;
        for (int c = 0; c < 24; c++) begin
            sysClkPhase = (c < 12) ? 3'd7 : 3'd6;
            @(posedge sysClk);
            #1;
            if (rgbValid) vcount++;
        end
        check("t5_no_tick_phase", 32'(vcount), 32'h0);

        // Reset between tick and stage 2 discards the pixel
        sysClkPhase = 3'd0;
        @(posedge sysClk);
        #1;
        nReset = 1'b0;
        #1;
        nReset = 1'b1;
        vcount = 0;
        for (int p = 1; p < 6; p++) begin
            sysClkPhase = 3'(p);
            @(posedge sysClk);
            #1;
            if (rgbValid) vcount++;
        end
        check("t5_inflight_drop", 32'(vcount), 32'h0);
        check("t5_inflight_out", 32'(rgbOut), 32'h0);
        expect_pixel("t5_recover", 18'h3FFFF, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
